// File: rtl/ysyx_l1i_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 instruction cache.
package ysyx_l1i_pkg;

  // Refill controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time constants (arguments are small positive ints).
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of the word-within-line offset field.
  function automatic int off_w(input int line_words);
    return clog2_int(line_words);
  endfunction

  // Width of the set index field.
  function automatic int idx_w(input int sets);
    return clog2_int(sets);
  endfunction

  // Width of the tag: everything above index, offset and the byte bits.
  function automatic int tag_w(input int xlen, input int sets, input int line_words);
    return xlen - idx_w(sets) - off_w(line_words) - 2;
  endfunction

endpackage

// File: rtl/ysyx_l1i_array.sv
// Data and tag storage for the L1I. Combinational read port for zero-latency
// hits, clocked write port driven by the refill engine. Kept separate so the
// storage can later be swapped for an SRAM macro without touching the FSM.
module ysyx_l1i_array
  import ysyx_l1i_pkg::*;
#(
  parameter int   XLEN       = 32,
  parameter int   SETS       = 4,
  parameter int   LINE_WORDS = 2,
  localparam int  OFF        = off_w(LINE_WORDS),
  localparam int  IDX        = idx_w(SETS),
  localparam int  TAG_W      = tag_w(XLEN, SETS, LINE_WORDS)
) (
  input  logic             clk,
  // write port (refill)
  input  logic             wr_en,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [OFF-1:0]   wr_off,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             tag_wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  // read port (fetch lookup)
  input  logic [IDX-1:0]   rd_idx,
  input  logic [OFF-1:0]   rd_off,
  output logic [XLEN-1:0]  rd_data,
  output logic [TAG_W-1:0] rd_tag
);

  // Per-row read results, gathered so the lookup is a single index mux.
  logic [XLEN-1:0]  row_word [SETS];
  logic [TAG_W-1:0] row_tag  [SETS];

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_row
      logic [XLEN-1:0]  word_q [LINE_WORDS];
      logic [TAG_W-1:0] tag_q;
      logic             row_sel;

      assign row_sel = (wr_idx == IDX'(gi));

      // Capture refill beats into this row; the tag lands with the last beat.
      always_ff @(posedge clk) begin
        if (wr_en && row_sel) begin
          word_q[wr_off] <= wr_data;
        end
        if (tag_wr_en && row_sel) begin
          tag_q <= wr_tag;
        end
      end

      assign row_word[gi] = word_q[rd_off];
      assign row_tag[gi]  = tag_q;
    end
  endgenerate

  assign rd_data = row_word[rd_idx];
  assign rd_tag  = row_tag[rd_idx];

endmodule

// File: rtl/ysyx_l1i.sv
// Direct-mapped L1 instruction cache. Serves the IFU with zero-latency hits and
// refills a whole line on a miss, either as one incrementing burst or as one
// single-beat read per word depending on the line address. A FENCE.I arriving
// mid-refill is remembered and applied when the refill completes.
module ysyx_l1i
  import ysyx_l1i_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              SETS       = 4,
  parameter int              LINE_WORDS = 2,
  parameter bit              BURST_EN   = 1'b1,
  parameter logic [XLEN-1:0] BURST_LO   = 'ha0000000,
  parameter logic [XLEN-1:0] BURST_HI   = 'hc0000000
) (
  input  logic            clk,
  input  logic            rst,
  // IFU fetch port
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_valid,
  output logic [XLEN-1:0] inst_o,
  output logic            hit_o,
  output logic            ready_o,
  input  logic            invalidate,
  // instruction bus
  output logic [XLEN-1:0] araddr_o,
  output logic            arvalid_o,
  output logic            arburst_o,
  output logic [7:0]      arlen_o,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic            rvalid,
  output logic            required_o
);

  localparam int OFF     = off_w(LINE_WORDS);
  localparam int IDX     = idx_w(SETS);
  localparam int TAG_W   = tag_w(XLEN, SETS, LINE_WORDS);
  localparam int LSB_IDX = OFF + 2;
  localparam int LSB_TAG = IDX + OFF + 2;

  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);
  localparam logic [7:0]     BURST_LEN = 8'(LINE_WORDS - 1);

  // Controller state.
  state_e            state_q, state_d;
  logic [OFF-1:0]    beat_q, beat_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic              burst_q, burst_d;
  logic              pend_inv_q, pend_inv_d;
  logic [SETS-1:0]   valid_q, valid_d;

  // Fetch address split.
  logic [OFF-1:0]    pc_off;
  logic [IDX-1:0]    pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [XLEN-1:0]   miss_base;
  logic              burst_sel;

  // Refill line split.
  logic [IDX-1:0]    base_idx;
  logic [TAG_W-1:0]  base_tag;
  logic [XLEN-1:0]   beat_addr;

  // Storage interface.
  logic              arr_wr_en;
  logic              arr_tag_we;
  logic [XLEN-1:0]   rd_data;
  logic [TAG_W-1:0]  rd_tag;

  logic              idle;
  logic              hit;

  // The byte-within-word bits never select anything in an instruction cache.
  logic              unused_pc_lsb;
  assign unused_pc_lsb = ^fetch_pc[1:0];

  assign pc_off    = fetch_pc[LSB_IDX-1:2];
  assign pc_idx    = fetch_pc[LSB_TAG-1:LSB_IDX];
  assign pc_tag    = fetch_pc[XLEN-1:LSB_TAG];
  assign miss_base = {fetch_pc[XLEN-1:LSB_IDX], {LSB_IDX{1'b0}}};

  // Burst eligibility is decided on the line base, not the faulting word.
  assign burst_sel = BURST_EN && (miss_base >= BURST_LO) && (miss_base <= BURST_HI);

  assign base_idx  = base_q[LSB_TAG-1:LSB_IDX];
  assign base_tag  = base_q[XLEN-1:LSB_TAG];
  assign beat_addr = base_q + {{(XLEN-OFF-2){1'b0}}, beat_q, 2'b00};

  ysyx_l1i_array #(
    .XLEN       (XLEN),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .wr_en     (arr_wr_en),
    .wr_idx    (base_idx),
    .wr_off    (beat_q),
    .wr_data   (rdata),
    .tag_wr_en (arr_tag_we),
    .wr_tag    (base_tag),
    .rd_idx    (pc_idx),
    .rd_off    (pc_off),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag)
  );

  assign idle = (state_q == S_IDLE);

  // A same-cycle invalidate already masks the hit so the IFU never consumes a
  // word that is about to be flushed.
  assign hit = idle && valid_q[pc_idx] && (rd_tag == pc_tag) && !invalidate;

  assign hit_o      = hit;
  assign inst_o     = rd_data;
  assign ready_o    = idle;
  assign required_o = !idle;
  assign arvalid_o  = (state_q == S_AR);
  assign arburst_o  = arvalid_o && burst_q;
  assign arlen_o    = (arvalid_o && burst_q) ? BURST_LEN : 8'd0;
  assign araddr_o   = arvalid_o ? beat_addr : '0;

  // Next-state logic: miss detection, request handshake and beat collection.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    burst_d    = burst_q;
    pend_inv_d = pend_inv_q;
    valid_d    = valid_q;
    arr_wr_en  = 1'b0;
    arr_tag_we = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (invalidate) begin
          valid_d = '0;
        end
        if (fetch_valid && !hit) begin
          base_d  = miss_base;
          beat_d  = '0;
          burst_d = burst_sel;
          state_d = S_AR;
        end
      end

      S_AR: begin
        if (invalidate) begin
          pend_inv_d = 1'b1;
        end
        if (arready) begin
          state_d = S_R;
        end
      end

      S_R: begin
        if (invalidate) begin
          pend_inv_d = 1'b1;
        end
        if (rvalid) begin
          arr_wr_en = 1'b1;
          beat_d    = beat_q + OFF'(1);
          if (beat_q == LAST_BEAT) begin
            // Line complete: publish it unless a FENCE.I arrived meanwhile,
            // in which case every line, this one included, goes invalid.
            arr_tag_we = 1'b1;
            state_d    = S_IDLE;
            pend_inv_d = 1'b0;
            if (pend_inv_q || invalidate) begin
              valid_d = '0;
            end else begin
              valid_d[base_idx] = 1'b1;
            end
          end else if (burst_q) begin
            state_d = S_R;
          end else begin
            state_d = S_AR;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; the data/tag arrays deliberately carry no reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      burst_q    <= 1'b0;
      pend_inv_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      burst_q    <= burst_d;
      pend_inv_q <= pend_inv_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_l1i.sv
// Scoreboard bench for ysyx_l1i: stimulus pushes expected bus requests and hits,
// a monitor pops and compares them as the cache presents them.
module tb_ysyx_l1i;

  localparam int SETS = 4;
  localparam int LW   = 2;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] inst_o;
  logic        hit_o;
  logic        ready_o;
  logic        inv_drv;
  logic        inv_slv;
  logic        invalidate;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arburst_o;
  logic [7:0]  arlen_o;
  logic        arready;
  logic [31:0] rdata_slv;
  logic [31:0] rdata;
  logic        rvalid_slv;
  logic        stray_v;
  logic        rvalid;
  logic        required_o;

  assign invalidate = inv_drv | inv_slv;
  assign rvalid     = rvalid_slv | stray_v;
  assign rdata      = stray_v ? 32'hdeadbeef : rdata_slv;

  ysyx_l1i #(
    .XLEN       (32),
    .SETS       (SETS),
    .LINE_WORDS (LW),
    .BURST_EN   (1'b1),
    .BURST_LO   (32'ha0000000),
    .BURST_HI   (32'hc0000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .inst_o      (inst_o),
    .hit_o       (hit_o),
    .ready_o     (ready_o),
    .invalidate  (invalidate),
    .araddr_o    (araddr_o),
    .arvalid_o   (arvalid_o),
    .arburst_o   (arburst_o),
    .arlen_o     (arlen_o),
    .arready     (arready),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .required_o  (required_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int issue_cyc = 0;
  bit hit_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_hit;
    logic [31:0] addr;
    bit          burst;
    logic [7:0]  len;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        q[$];
  bit          mvalid[SETS];
  logic [31:0] mtag[SETS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    return (w * 32'h9e3779b1) ^ 32'h13579bdf;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LW * SETS);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a - (a % (4 * LW));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[idx_of(a)] && (mtag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
  endtask

  task automatic push_fill(input logic [31:0] base, input bit burst);
    exp_t e;
    e.is_hit = 1'b0;
    e.data   = '0;
    e.lat    = -1;
    if (burst) begin
      e.addr = base; e.burst = 1'b1; e.len = 8'(LW - 1);
      q.push_back(e);
    end else begin
      for (int w = 0; w < LW; w++) begin
        e.addr = base + 32'(4 * w); e.burst = 1'b0; e.len = 8'd0;
        q.push_back(e);
      end
    end
  endtask

  task automatic push_hit(input logic [31:0] pc, input int lat);
    exp_t e;
    e.is_hit = 1'b1; e.addr = pc; e.burst = 1'b0; e.len = 8'd0;
    e.data = mem_word(pc); e.lat = lat;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (arvalid_o && arready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ar: got request at %h, required none", araddr_o);
        end else begin
          mon_e = q.pop_front();
          check("ar_kind", 32'(mon_e.is_hit), 32'd0);
          check("ar_addr", araddr_o, mon_e.addr);
          check("ar_burst", 32'(arburst_o), 32'(mon_e.burst));
          check("ar_len", 32'(arlen_o), 32'(mon_e.len));
        end
      end
      if (fetch_valid && hit_o) begin
        hit_seen = 1'b1;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_hit: got hit at pc %h, required none", fetch_pc);
        end else begin
          mon_e = q.pop_front();
          check("hit_kind", 32'(mon_e.is_hit), 32'd1);
          check("inst", inst_o, mon_e.data);
          if (mon_e.lat >= 0) check("hit_latency", 32'(cyc - issue_cyc), 32'(mon_e.lat));
        end
      end
    end
  end

  // ---------------- bus slave ----------------
  int ar_wait = 0;
  int r_gap_max = 0;
  bit inv_at_fill = 0;
  bit slave_busy = 0;

  initial begin
    logic [31:0] a;
    int n;
    arready = 1'b0; rvalid_slv = 1'b0; rdata_slv = '0; inv_slv = 1'b0;
    forever begin
      if (rst && arvalid_o) begin
        slave_busy = 1'b1;
        a = araddr_o;
        n = int'(arlen_o) + 1;
        for (int k = 0; k < ar_wait; k++) begin
          check("ar_hold_valid", 32'(arvalid_o), 32'd1);
          check("ar_hold_addr", araddr_o, a);
          @(posedge clk); #1;
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < n; b++) begin
          repeat ($urandom_range(r_gap_max, 0)) begin @(posedge clk); #1; end
          rvalid_slv = 1'b1;
          rdata_slv  = mem_word(a + 32'(4 * b));
          if (b == 0 && inv_at_fill) begin
            inv_slv = 1'b1;
            inv_at_fill = 1'b0;
          end
          @(posedge clk); #1;
          rvalid_slv = 1'b0;
          inv_slv = 1'b0;
        end
        slave_busy = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fetch(input logic [31:0] pc);
    int          ix;
    logic [31:0] base;
    bit          burst;
    bit          zw;
    ix   = idx_of(pc);
    base = base_of(pc);
    if (model_hit(pc)) begin
      push_hit(pc, 0);
    end else begin
      burst = (base >= 32'ha0000000) && (base <= 32'hc0000000);
      zw    = (ar_wait == 0) && (r_gap_max == 0) && !inv_at_fill;
      push_fill(base, burst);
      if (inv_at_fill) begin
        push_fill(base, burst);
        model_clear();
      end
      mvalid[ix] = 1'b1;
      mtag[ix]   = tag_of(pc);
      push_hit(pc, zw ? (burst ? LW + 2 : 1 + 2 * LW) : -1);
    end
    fetch_pc = pc; fetch_valid = 1'b1; issue_cyc = cyc; hit_seen = 1'b0;
    for (int k = 0; k < 300 && !hit_seen; k++) begin @(posedge clk); #1; end
    if (!hit_seen) begin
      checks++;
      $display("FAIL fetch_timeout: pc %h got no hit_o, required one within 300 cycles", pc);
      q.delete();
    end
    fetch_valid = 1'b0;
    inv_at_fill = 1'b0;
  endtask

  task automatic idle_inv(input logic [31:0] pc);
    fetch_pc = pc;
    @(negedge clk);
    check("hit_before_inv", 32'(hit_o), 32'(model_hit(pc)));
    @(posedge clk); #1;
    inv_drv = 1'b1;
    @(negedge clk);
    check("hit_during_inv", 32'(hit_o), 32'd0);
    @(posedge clk); #1;
    inv_drv = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hit"}, 32'(hit_o), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_arvalid"}, 32'(arvalid_o), 32'd0);
    check({tag, "_required"}, 32'(required_o), 32'd0);
    check({tag, "_arburst"}, 32'(arburst_o), 32'd0);
    check({tag, "_arlen"}, 32'(arlen_o), 32'd0);
    check({tag, "_araddr"}, araddr_o, 32'd0);
  endtask

  logic [31:0] regions[5] = '{32'h30000000, 32'h80000000, 32'ha0000000, 32'hbfffff80, 32'hc0000000};

  initial begin
    logic [31:0] pc;
    int k;
    fetch_pc = '0; fetch_valid = 1'b0; inv_drv = 1'b0; stray_v = 1'b0;
    model_clear();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // cold miss, single-beat refill
    fetch(32'h30000008);
    fetch(32'h3000000c);
    // burst refill
    fetch(32'ha0000104);
    fetch(32'ha0000100);
    // conflict on index 0
    fetch(32'h80000000);
    fetch(32'h80000040);
    fetch(32'h80000000);
    // burst window edges
    fetch(32'hc0000004);
    fetch(32'hc0000008);
    fetch(32'h9ffffffc);
    fetch(32'hbffffff8);
    // FENCE.I during beat 0 of a burst
    inv_at_fill = 1'b1;
    fetch(32'ha0000300);
    fetch(32'ha0000304);
    // FENCE.I while idle
    idle_inv(32'ha0000300);
    fetch(32'ha0000300);
    // slow arready
    ar_wait = 5;
    fetch(32'h30000100);
    ar_wait = 0;
    // rvalid while idle is ignored
    stray_v = 1'b1;
    @(negedge clk);
    check("stray_ready", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    stray_v = 1'b0;
    fetch(32'h30000104);

    // reset in the middle of a refill
    r_gap_max = 3;
    pc = 32'ha0000200;
    push_fill(base_of(pc), 1'b1);
    fetch_pc = pc; fetch_valid = 1'b1;
    k = 0;
    while (k < 60 && !(required_o && !arvalid_o)) begin @(posedge clk); #1; k++; end
    if (k == 60) begin
      checks++;
      $display("FAIL reach_r: got no R state, required within 60 cycles");
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("midr");
    q.delete();
    model_clear();
    fetch_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    k = 0;
    while (k < 60 && slave_busy) begin @(posedge clk); #1; k++; end
    r_gap_max = 0;
    fetch(32'h30000100);
    fetch(pc);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      pc = regions[$urandom_range(4, 0)] + 32'($urandom_range(63, 0) * 4);
      ar_wait   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      r_gap_max = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
      k = int'($urandom_range(9, 0));
      if (k == 0) idle_inv(pc);
      else if (k == 1 && !model_hit(pc)) inv_at_fill = 1'b1;
      fetch(pc);
    end
    ar_wait = 0; r_gap_max = 0;

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
